alu_arbiter: RTL and testbench

Sequencing and sharing controller for the 16-bit combinational `alu`. Two requesters each present an opcode and operands over a valid/ready handshake. The block arbitrates between them, registers the winning operation, drives one shared `alu` instance, and returns the registered result, carry and zero flags on the winner's response channel. It sits between the instruction-execution units and the ALU, so the ALU is never driven by two sources at once.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 36 +++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbitration wrapper: widths, opcodes
// and the sequencer state encoding.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHR = 3'd6,
    OP_SHL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU. Every operation is evaluated in a 17-bit context
// so that bit 16 is the carry/borrow flag.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              cy_o,
  output logic              zero_o
);

  logic [DATA_W:0] wide;

  always_comb begin
    // NOTE: default first so every path assigns wide; otherwise a latch is inferred.
    wide = '0;
    case (opcode_e'(op_i))
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      OP_NOT:  wide = {1'b1, ~a_i};
      OP_SHR:  wide = {1'b0, a_i >> b_i};
      OP_SHL:  wide = {1'b0, a_i} << b_i;
      default: wide = '0;
    endcase
  end

  assign result_o = wide[DATA_W-1:0];
  assign cy_o     = wide[DATA_W];
  assign zero_o   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: arbitrates, registers the
// winning operation, runs it once and returns the registered result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [2:0]        req0_opcode,
  input  logic [2:0]        req1_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp0_cy,
  output logic              rsp1_cy,
  output logic              rsp0_zero,
  output logic              rsp1_zero,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cy_q, cy_d, zero_q, zero_d;

  logic              winner;
  logic              rsp_hs;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cy, alu_zero;

  alu u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .result_o(alu_result),
    .cy_o    (alu_cy),
    .zero_o  (alu_zero)
  );

  // A lone requester always wins; a tie goes to whoever was not served last
  // (round-robin) or to requester 0 (fixed priority).
  always_comb begin
    if (req0_valid && req1_valid) winner = RR ? ~last_grant_q : 1'b0;
    else                          winner = req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && !winner && req0_valid;
  assign req1_ready = (state_q == IDLE) &&  winner && req1_valid;
  assign rsp_hs     = grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    cy_d         = cy_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = EXEC;
          grant_d = winner;
          op_d    = winner ? req1_opcode : req0_opcode;
          a_d     = winner ? req1_a      : req0_a;
          b_d     = winner ? req1_b      : req0_b;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        cy_d    = alu_cy;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
          if (RR) last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so outputs read 0 and an
    // interrupted operation leaves nothing behind after release.
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cy_q         <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      cy_q         <= cy_d;
      zero_q       <= zero_d;
    end
  end

  assign rsp0_valid  = (state_q == RESP) && !grant_q;
  assign rsp1_valid  = (state_q == RESP) &&  grant_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_cy     = cy_q;
  assign rsp1_cy     = cy_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push hand-computed
// responses; a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        cy;
    logic        zero;
  } exp_t;

  logic clk, rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_opcode, req1_opcode;
  logic [15:0] req0_a, req1_a, req0_b, req1_b;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_result, rsp1_result;
  logic rsp0_cy, rsp1_cy, rsp0_zero, rsp1_zero, busy;

  logic fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
  logic fp_rsp0_valid, fp_rsp1_valid;
  logic [15:0] fp_rsp0_result, fp_rsp1_result;
  logic fp_rsp0_cy, fp_rsp1_cy, fp_rsp0_zero, fp_rsp1_zero, fp_busy;

  exp_t sb[$];
  int   grant_order[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter #(.RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_cy(rsp0_cy), .rsp1_cy(rsp1_cy),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  alu_arbiter #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fp_req0_valid), .req1_valid(fp_req1_valid),
    .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(fp_rsp0_result), .rsp1_result(fp_rsp1_result),
    .rsp0_cy(fp_rsp0_cy), .rsp1_cy(fp_rsp1_cy),
    .rsp0_zero(fp_rsp0_zero), .rsp1_zero(fp_rsp1_zero),
    .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic score(input logic id, input logic [15:0] r, input logic cy, input logic z);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got response on channel %0d result 0x%0h, expected none", id, r);
      return;
    end
    e = sb.pop_front();
    check("sb_id", id, e.id);
    check("sb_result", r, e.res);
    check("sb_cy", cy, e.cy);
    check("sb_zero", z, e.zero);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid || rsp1_valid) check("rsp_onehot", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid && rsp0_ready) score(1'b0, rsp0_result, rsp0_cy, rsp0_zero);
      if (rsp1_valid && rsp1_ready) score(1'b1, rsp1_result, rsp1_cy, rsp1_zero);
    end
  end

  task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (!id) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic wait_accept(input logic id);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
    end
    if (!ok) expired("accept");
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic ecy,
                       input logic ez);
    sb.push_back('{id, er, ecy, ez});
    set_req(id, 1'b1, op, a, b);
    wait_accept(id);
    set_req(id, 1'b0, op, a, b);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) expired("drain");
    @(posedge clk); #1;
  endtask

  // Hold both requests until n grants are seen, logging who won each.
  task automatic tie_run(input int n);
    int g;
    grant_order.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 60 && grant_order.size() < n; i++) begin
      @(negedge clk);
      if (req0_ready) grant_order.push_back(0);
      if (req1_ready) grant_order.push_back(1);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (grant_order.size() != n) expired("tie_grants");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, nr0, nr1;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; fp_req0_valid = 0; fp_req1_valid = 0;
    req0_opcode = 0; req1_opcode = 0; req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_result", rsp0_result, 0);
    check("rst_flags", {rsp0_cy, rsp0_zero, rsp1_cy, rsp1_zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: add with carry out and latency
    sb.push_back('{1'b0, 16'h0000, 1'b1, 1'b1});
    set_req(1'b0, 1'b1, OP_ADD, 16'hFFFF, 16'h0001);
    @(negedge clk);
    check("t1_ready", req0_ready, 1);
    check("t1_busy_idle", busy, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_exec_no_valid", rsp0_valid, 0);
    check("t1_exec_busy", busy, 1);
    @(negedge clk);
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp1_quiet", rsp1_valid, 0);
    drain();

    // 2: round-robin ties from reset
    do_reset();
    sb.push_back('{1'b0, 16'hFFFE, 1'b1, 1'b0});
    sb.push_back('{1'b1, 16'h000F, 1'b0, 1'b0});
    sb.push_back('{1'b0, 16'hFFFE, 1'b1, 1'b0});
    sb.push_back('{1'b1, 16'h000F, 1'b0, 1'b0});
    set_req(1'b0, 1'b0, OP_SUB, 16'd5, 16'd7);
    set_req(1'b1, 1'b0, OP_AND, 16'h0F0F, 16'h00FF);
    tie_run(4);
    for (int i = 0; i < grant_order.size(); i++)
      check($sformatf("t2_grant%0d", i), grant_order[i], i % 2);
    drain();

    // 3: response backpressure on channel 0 while req1 waits
    rsp0_ready = 1'b0;
    sb.push_back('{1'b0, 16'h0007, 1'b0, 1'b0});
    sb.push_back('{1'b1, 16'h00FF, 1'b0, 1'b0});
    set_req(1'b1, 1'b1, OP_OR, 16'h00F0, 16'h000F);
    set_req(1'b0, 1'b1, OP_ADD, 16'd3, 16'd4);
    wait_accept(1'b0);
    req0_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp0_valid; i++) @(negedge clk);
    if (!rsp0_valid) expired("t3_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_result", rsp0_result, 16'h0007);
      check("t3_hold_flags", {rsp0_cy, rsp0_zero}, 0);
      check("t3_req1_masked", req1_ready, 0);
      check("t3_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_req1_accept", req1_ready, 1);
    check("t3_idle", busy, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // 4: flag corners, on both channels
    issue(1'b0, OP_SHL, 16'h8001, 16'd1,  16'h0002, 1'b1, 1'b0);
    issue(1'b1, OP_SHR, 16'h8000, 16'd15, 16'h0001, 1'b0, 1'b0);
    issue(1'b1, OP_XOR, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
    issue(1'b0, OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b1, 1'b0);
    drain();

    // 5: reset during EXEC drops the operation
    set_req(1'b1, 1'b1, OP_ADD, 16'h1111, 16'h2222);
    wait_accept(1'b1);
    req1_valid = 1'b0;
    check("t5_exec_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", {rsp1_valid, rsp0_valid}, 0);
    check("t5_rst_result", rsp1_result, 0);
    check("t5_rst_flags", {rsp0_cy, rsp0_zero}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    end
    @(posedge clk); #1;
    sb.push_back('{1'b0, 16'h0005, 1'b0, 1'b0});
    sb.push_back('{1'b1, 16'h0000, 1'b0, 1'b1});
    set_req(1'b0, 1'b0, OP_ADD, 16'd2, 16'd3);
    set_req(1'b1, 1'b0, OP_SUB, 16'd7, 16'd7);
    tie_run(2);
    if (grant_order.size() > 0) check("t5_first_grant", grant_order[0], 0);
    drain();

    // 6: fixed priority starves requester 1
    do_reset();
    set_req(1'b0, 1'b0, OP_ADD, 16'd1, 16'd1);
    set_req(1'b1, 1'b0, OP_SUB, 16'd9, 16'd4);
    fp_req0_valid = 1'b1;
    fp_req1_valid = 1'b1;
    g0 = 0; g1 = 0; nr0 = 0; nr1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      g0 += int'(fp_req0_ready);
      g1 += int'(fp_req1_ready);
      nr1 += int'(fp_rsp1_valid);
      if (fp_rsp0_valid) begin
        nr0++;
        check("t6_result", fp_rsp0_result, 16'h0002);
      end
    end
    @(posedge clk); #1;
    fp_req0_valid = 1'b0;
    fp_req1_valid = 1'b0;
    check("t6_grants0", g0, 10);
    check("t6_grants1", g1, 0);
    check("t6_rsp0_count", nr0, 10);
    check("t6_rsp1_count", nr1, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
